// File: rtl/bf16_pkg.sv
// Purpose: shared types and constants for the BF16 result packing path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bf16_pkg;

    typedef logic [15:0] bf16_t;
    typedef logic [3:0]  fpcsr_t;

    // fpcsr bit positions
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Canonical quiet NaN
    localparam bf16_t BF16_QNAN = 16'h7FC0;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_e;

    // True for any NaN encoding: all-ones exponent, non-zero mantissa
    function automatic logic bf16_is_nan(input bf16_t v);
        return (v[14:7] == 8'hFF) && (v[6:0] != 7'd0);
    endfunction

endpackage

// File: rtl/bf16_out_reg.sv
// Purpose: single-entry valid/ready output register holding a packed word, partial bit and flags.
// Latency: 1 cycle from load to out_valid.
// Backpressure: contents held stable while out_valid & !out_ready; slot_free tells the producer when a load is legal.
module bf16_out_reg
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_vld,
    input  logic [31:0] load_dat,
    input  logic        load_partial,
    input  fpcsr_t      load_flags,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_partial,
    output fpcsr_t      out_flags,
    output logic        slot_free
);

    logic        valid_d,   valid_q;
    logic [31:0] data_d,    data_q;
    logic        partial_d, partial_q;
    fpcsr_t      flags_d,   flags_q;

    assign slot_free   = !valid_q || out_ready;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_partial = partial_q;
    assign out_flags   = flags_q;

    // Next contents: take a new word when loaded, otherwise hold; valid drops after handshake
    always_comb begin
        valid_d   = valid_q && !out_ready;
        data_d    = data_q;
        partial_d = partial_q;
        flags_d   = flags_q;
        if (load_vld) begin
            valid_d   = 1'b1;
            data_d    = load_dat;
            partial_d = load_partial;
            flags_d   = load_flags;
        end
    end

    // Register state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= 32'd0;
            partial_q <= 1'b0;
            flags_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            partial_q <= partial_d;
            flags_q   <= flags_d;
        end
    end

endmodule

// File: rtl/bf16_result_packer.sv
// Purpose: packs two BF16 results into one 32-bit writeback word, tracks sticky fpcsr; macro BF16_PACK_NAN_CANON_EN enables NaN canonicalisation.
// Latency: 1 cycle from the completing accept (or flush) to out_valid.
// Backpressure: in_ready drops when a word must be emitted but the output register is occupied and not draining.
module bf16_result_packer
    import bf16_pkg::*;
#(
    parameter logic [15:0] PAD_VALUE = 16'h0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_result,
    input  logic [3:0]       in_flags,
    input  logic             flush,
    input  logic             flags_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_partial,
    output logic [3:0]       out_flags,
    output logic [3:0]       sticky_flags,
    output logic [CNT_W-1:0] word_count
);

    pack_state_e      state_d, state_q;
    bf16_t            lo_d, lo_q;
    fpcsr_t           lo_flags_d, lo_flags_q;
    logic             flush_pend_d, flush_pend_q;
    fpcsr_t           sticky_d, sticky_q;
    logic [CNT_W-1:0] count_d, count_q;

    logic        slot_free;
    logic        accept;
    logic        in_ready_c;
    bf16_t       res_c;
    fpcsr_t      flg_c;
    logic        emit_vld;
    logic [31:0] emit_dat;
    logic        emit_partial;
    fpcsr_t      emit_flags;
    logic        flush_eff;

    assign accept   = in_valid && in_ready_c;
    assign in_ready = in_ready_c;

    // Incoming result/flags, optionally canonicalising NaNs
    always_comb begin
        res_c = in_result;
        flg_c = in_flags;
`ifdef BF16_PACK_NAN_CANON_EN
        if (bf16_is_nan(in_result)) begin
            res_c          = BF16_QNAN;
            flg_c[FLAG_NV] = 1'b1;
        end
`endif
    end

    // Pack FSM: decide readiness, what to emit and the next held half
    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        lo_flags_d   = lo_flags_q;
        flush_pend_d = flush_pend_q;
        in_ready_c   = 1'b1;
        emit_vld     = 1'b0;
        emit_dat     = 32'd0;
        emit_partial = 1'b0;
        emit_flags   = '0;
        flush_eff    = flush || flush_pend_q;
        case (state_q)
            EMPTY: begin
                flush_pend_d = 1'b0;
                // A flushed lone result goes straight out, so it needs the slot now
                in_ready_c = !(flush && in_valid && !slot_free);
                if (accept) begin
                    if (flush) begin
                        emit_vld     = 1'b1;
                        emit_dat     = {PAD_VALUE, res_c};
                        emit_partial = 1'b1;
                        emit_flags   = flg_c;
                    end else begin
                        lo_d       = res_c;
                        lo_flags_d = flg_c;
                        state_d    = HALF;
                    end
                end
            end
            HALF: begin
                in_ready_c = slot_free;
                if (accept) begin
                    // Pair completes; any flush in the same cycle has nothing left to emit
                    emit_vld     = 1'b1;
                    emit_dat     = {res_c, lo_q};
                    emit_flags   = lo_flags_q | flg_c;
                    state_d      = EMPTY;
                    flush_pend_d = 1'b0;
                end else if (flush_eff) begin
                    if (slot_free) begin
                        emit_vld     = 1'b1;
                        emit_dat     = {PAD_VALUE, lo_q};
                        emit_partial = 1'b1;
                        emit_flags   = lo_flags_q;
                        state_d      = EMPTY;
                        flush_pend_d = 1'b0;
                    end else begin
                        flush_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Sticky flags (clear applies before the OR) and handshake counter
    always_comb begin
        sticky_d = sticky_q;
        if (flags_clear) begin
            sticky_d = '0;
        end
        if (accept) begin
            sticky_d = sticky_d | flg_c;
        end
        count_d = count_q;
        if (out_valid && out_ready) begin
            count_d = count_q + 1'b1;
        end
    end

    // Register FSM and bookkeeping state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            lo_q         <= '0;
            lo_flags_q   <= '0;
            flush_pend_q <= 1'b0;
            sticky_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            lo_flags_q   <= lo_flags_d;
            flush_pend_q <= flush_pend_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
        end
    end

    assign sticky_flags = sticky_q;
    assign word_count   = count_q;

    bf16_out_reg u_out_reg (
        .clk          (clk),
        .reset        (reset),
        .load_vld     (emit_vld),
        .load_dat     (emit_dat),
        .load_partial (emit_partial),
        .load_flags   (emit_flags),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_partial  (out_partial),
        .out_flags    (out_flags),
        .slot_free    (slot_free)
    );

endmodule

// File: tb/tb_bf16_result_packer.sv
// Purpose: directed, table-driven checks of the BF16 result packer plus reset and wrap sequences.
// Latency: one vector per clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: exercised through out_ready in the vector table.
module tb_bf16_result_packer;

    localparam int CNT_W = 4;

`ifdef BF16_PACK_NAN_CANON_EN
    localparam logic [15:0] NAN_EXP = 16'h7FC0;
    localparam logic [3:0]  NAN_F   = 4'h8;
`else
    localparam logic [15:0] NAN_EXP = 16'hFF81;
    localparam logic [3:0]  NAN_F   = 4'h0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_result;
    logic [3:0]       in_flags;
    logic             flush;
    logic             flags_clear;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_partial;
    logic [3:0]       out_flags;
    logic [3:0]       sticky_flags;
    logic [CNT_W-1:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bf16_result_packer #(.PAD_VALUE(16'h0000), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .flush        (flush),
        .flags_clear  (flags_clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_partial  (out_partial),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .word_count   (word_count)
    );

    typedef struct {
        logic        iv;
        logic [15:0] res;
        logic [3:0]  flg;
        logic        fl;
        logic        clr;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_dat;
        logic        e_part;
        logic [3:0]  e_oflg;
        logic [3:0]  e_sticky;
        logic [3:0]  e_cnt;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic iv, input logic [15:0] res, input logic [3:0] flg,
                                input logic fl, input logic clr, input logic ordy,
                                input logic e_rdy, input logic e_ov, input logic [31:0] e_dat,
                                input logic e_part, input logic [3:0] e_oflg,
                                input logic [3:0] e_sticky, input logic [3:0] e_cnt);
        vec_t v;
        v.iv = iv; v.res = res; v.flg = flg; v.fl = fl; v.clr = clr; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_dat = e_dat; v.e_part = e_part;
        v.e_oflg = e_oflg; v.e_sticky = e_sticky; v.e_cnt = e_cnt;
        return v;
    endfunction

    function automatic vec_t idle(input logic [3:0] st, input logic [3:0] cnt);
        return mk(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, st, cnt);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] res, input logic [3:0] flg,
                         input logic fl, input logic clr, input logic ordy);
        in_valid    = iv;
        in_result   = res;
        in_flags    = flg;
        flush       = fl;
        flags_clear = clr;
        out_ready   = ordy;
    endtask

    initial begin
        vecs[0]  = mk(1, 16'h3F80, 4'h0, 0, 0, 1, 1, 0, 32'h0,        0, 4'h0, 4'h0, 4'd0);
        vecs[1]  = mk(1, 16'h4000, 4'h1, 0, 0, 1, 1, 1, 32'h40003F80, 0, 4'h1, 4'h1, 4'd0);
        vecs[2]  = mk(1, 16'h3F80, 4'h0, 0, 0, 1, 1, 0, 32'h0,        0, 4'h0, 4'h1, 4'd1);
        vecs[3]  = mk(0, 16'h0000, 4'h0, 1, 0, 1, 1, 1, 32'h00003F80, 1, 4'h0, 4'h1, 4'd1);
        vecs[4]  = idle(4'h1, 4'd2);
        vecs[5]  = mk(1, 16'h1111, 4'h0, 0, 0, 0, 1, 0, 32'h0,        0, 4'h0, 4'h1, 4'd2);
        vecs[6]  = mk(1, 16'h2222, 4'h0, 0, 0, 0, 1, 1, 32'h22221111, 0, 4'h0, 4'h1, 4'd2);
        vecs[7]  = mk(1, 16'h3333, 4'h2, 0, 0, 0, 1, 1, 32'h22221111, 0, 4'h0, 4'h3, 4'd2);
        vecs[8]  = mk(1, 16'h4444, 4'h0, 0, 0, 0, 0, 1, 32'h22221111, 0, 4'h0, 4'h3, 4'd2);
        vecs[9]  = mk(1, 16'h4444, 4'h0, 0, 0, 1, 1, 1, 32'h44443333, 0, 4'h2, 4'h3, 4'd3);
        vecs[10] = idle(4'h3, 4'd4);
        vecs[11] = mk(1, 16'h5555, 4'h0, 0, 0, 0, 1, 0, 32'h0,        0, 4'h0, 4'h3, 4'd4);
        vecs[12] = mk(1, 16'h6666, 4'h0, 0, 0, 0, 1, 1, 32'h66665555, 0, 4'h0, 4'h3, 4'd4);
        vecs[13] = mk(1, 16'h7777, 4'h4, 0, 0, 0, 1, 1, 32'h66665555, 0, 4'h0, 4'h7, 4'd4);
        vecs[14] = mk(0, 16'h0000, 4'h0, 1, 0, 0, 0, 1, 32'h66665555, 0, 4'h0, 4'h7, 4'd4);
        vecs[15] = mk(0, 16'h0000, 4'h0, 0, 0, 1, 1, 1, 32'h00007777, 1, 4'h4, 4'h7, 4'd5);
        vecs[16] = idle(4'h7, 4'd6);
        vecs[17] = mk(1, 16'h8888, 4'h0, 0, 0, 0, 1, 0, 32'h0,        0, 4'h0, 4'h7, 4'd6);
        vecs[18] = mk(1, 16'h9999, 4'h0, 0, 0, 0, 1, 1, 32'h99998888, 0, 4'h0, 4'h7, 4'd6);
        vecs[19] = mk(1, 16'hAAAA, 4'h8, 1, 0, 0, 0, 1, 32'h99998888, 0, 4'h0, 4'h7, 4'd6);
        vecs[20] = mk(1, 16'hAAAA, 4'h8, 1, 0, 1, 1, 1, 32'h0000AAAA, 1, 4'h8, 4'hF, 4'd7);
        vecs[21] = idle(4'hF, 4'd8);
        vecs[22] = mk(1, 16'hBBBB, 4'h0, 0, 0, 1, 1, 0, 32'h0,        0, 4'h0, 4'hF, 4'd8);
        vecs[23] = mk(1, 16'hCCCC, 4'h0, 1, 0, 1, 1, 1, 32'hCCCCBBBB, 0, 4'h0, 4'hF, 4'd8);
        vecs[24] = idle(4'hF, 4'd9);
        vecs[25] = mk(0, 16'h0000, 4'h0, 1, 0, 1, 1, 0, 32'h0,        0, 4'h0, 4'hF, 4'd9);
        vecs[26] = mk(0, 16'h0000, 4'h0, 0, 1, 1, 1, 0, 32'h0,        0, 4'h0, 4'h0, 4'd9);
        vecs[27] = mk(1, 16'h0001, 4'h8, 0, 0, 1, 1, 0, 32'h0,        0, 4'h0, 4'h8, 4'd9);
        vecs[28] = mk(1, 16'h0002, 4'h4, 0, 0, 1, 1, 1, 32'h00020001, 0, 4'hC, 4'hC, 4'd9);
        vecs[29] = mk(1, 16'h0003, 4'h1, 0, 1, 1, 1, 0, 32'h0,        0, 4'h0, 4'h1, 4'd10);
        vecs[30] = mk(1, 16'hFF81, 4'h0, 0, 0, 1, 1, 1, {NAN_EXP, 16'h0003}, 0,
                      4'h1 | NAN_F, 4'h1 | NAN_F, 4'd10);
        vecs[31] = idle(4'h1 | NAN_F, 4'd11);

        // Reset state
        drive(0, 16'h0, 4'h0, 0, 0, 1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset out_partial", {31'd0, out_partial}, 32'd0);
        chk("reset out_flags", {28'd0, out_flags}, 32'd0);
        chk("reset sticky", {28'd0, sticky_flags}, 32'd0);
        chk("reset count", {28'd0, word_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Vector table: drive at negedge, check ready before the edge, outputs after it
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].iv, vecs[i].res, vecs[i].flg, vecs[i].fl, vecs[i].clr, vecs[i].ordy);
            #2;
            chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            chk($sformatf("v%0d sticky", i), {28'd0, sticky_flags}, {28'd0, vecs[i].e_sticky});
            chk($sformatf("v%0d count", i), {28'd0, word_count}, {28'd0, vecs[i].e_cnt});
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d out_data", i), out_data, vecs[i].e_dat);
                chk($sformatf("v%0d out_partial", i), {31'd0, out_partial}, {31'd0, vecs[i].e_part});
                chk($sformatf("v%0d out_flags", i), {28'd0, out_flags}, {28'd0, vecs[i].e_oflg});
            end
            @(negedge clk);
        end

        // Reset mid-operation: pending word and held half are both discarded
        drive(1, 16'hDEAD, 4'h0, 0, 0, 0);
        @(negedge clk);
        drive(1, 16'hBEEF, 4'h0, 0, 0, 0);
        @(negedge clk);
        drive(1, 16'hCAFE, 4'h0, 0, 0, 0);
        @(negedge clk);
        drive(0, 16'h0, 4'h0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset count", {28'd0, word_count}, 32'd0);
        chk("midreset sticky", {28'd0, sticky_flags}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 16'h1234, 4'h2, 1, 0, 1);
        #2;
        chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("midreset lone out_valid", {31'd0, out_valid}, 32'd1);
        chk("midreset lone out_data", out_data, 32'h00001234);
        chk("midreset lone partial", {31'd0, out_partial}, 32'd1);
        @(negedge clk);
        drive(0, 16'h0, 4'h0, 0, 0, 1);
        @(negedge clk);
        chk("midreset lone count", {28'd0, word_count}, 32'd1);

        // Counter wrap: 15 more words at full rate brings the count to 16 -> 0
        begin
            int stalls;
            stalls = 0;
            for (int b = 0; b < 30; b++) begin
                drive(1, 16'(b), 4'h0, 0, 0, 1);
                #2;
                if (!in_ready) stalls++;
                @(negedge clk);
            end
            chk("wrap full-rate stalls", 32'(stalls), 32'd0);
            chk("wrap count before last handshake", {28'd0, word_count}, 32'd15);
            chk("wrap last out_data", out_data, 32'h001D001C);
            drive(0, 16'h0, 4'h0, 0, 0, 1);
            @(negedge clk);
            chk("wrap count", {28'd0, word_count}, 32'd0);
            chk("wrap out_valid", {31'd0, out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bf16_result_packer.md
Name: bf16_result_packer

Overview:
Downstream neighbour of the FP32→BF16 conversion stage. Consumes one BF16 result plus its 4-bit fpcsr flags per accepted beat. Packs two results into one 32-bit writeback word and presents it on a valid/ready output register. Keeps a sticky accumulated fpcsr for the core's CSR read.

Parameters:
PAD_VALUE, 16'h0000, upper half-word inserted when a flush emits a lone result
CNT_W, 16, width of emitted-word counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  upstream result valid
in_ready  out  1  block can accept in_result this cycle
in_result  in  16  BF16 result from converter
in_flags  in  4  fpcsr of that result ([3] invalid, [2] overflow, [1] underflow, [0] inexact)
flush  in  1  emit any held half-word as a partial word
flags_clear  in  1  clear sticky flags
out_valid  out  1  packed word valid
out_ready  in  1  consumer accepts word
out_data  out  32  {hi, lo}; first-accepted result in [15:0]
out_partial  out  1  word holds only lo; hi = PAD_VALUE
out_flags  out  4  OR of in_flags of the results in this word
sticky_flags  out  4  accumulated flags since reset/clear
word_count  out  CNT_W  words handed off (out handshake count), wraps

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on reset. All outputs and state clear on reset: out_valid=0, out_data=0, out_partial=0, out_flags=0, sticky_flags=0, word_count=0, FSM=EMPTY.
- Reset mid-operation discards any held half and any pending output word. No emission.
- Input accept = in_valid & in_ready. Output handshake = out_valid & out_ready.
- Output slot free = !out_valid | out_ready.
- FSM states:
  - EMPTY (no half held): in_ready=1. Accept without flush → store lo and its flags, go to HALF. Accept with flush → needs slot free; if free, emit {PAD_VALUE, in_result} with partial=1, stay EMPTY.
  - EMPTY with flush and accept but slot not free: in_ready=0 for that cycle.
  - HALF: in_ready = slot free. Accept → emit {in_result, lo} with partial=0 and out_flags = lo_flags | in_flags, go to EMPTY.
  - HALF, flush without accept, slot free → emit {PAD_VALUE, lo} with partial=1, go to EMPTY. If slot not free, the flush is held pending until it can be emitted.
  - HALF, flush with accept in the same cycle → the pair completes normally. The flush is consumed with nothing left to emit.
- Emit = out register loads data/flags and out_valid=1 on the next edge. Latency: 1 cycle from the completing accept to out_valid.
- out_valid drops after a handshake unless a new emit happens in the same cycle. Back-to-back words are sustained at full rate when out_ready=1.
- out_data/out_partial/out_flags stay stable while out_valid=1 & out_ready=0.
- sticky_flags: each accept ORs in_flags. If flags_clear and accept happen together, the result = in_flags (clear first, then OR).
- word_count +1 on each out handshake; wraps 2^CNT_W-1 → 0.
- in_result is passed through bit-exact. There is no BF16 arithmetic in the base build.

Optional Feature:
Macro BF16_PACK_NAN_CANON_EN.
- Defined: any accepted in_result with exponent 8'hFF and mantissa≠0 is replaced by 16'h7FC0 before packing. The flags of that beat get bit[3] forced to 1.
- Undefined: results pass unmodified and flags are taken as given.

Decomposition:
- Shared package bf16_pkg:
  - typedef bf16_t (16-bit)
  - typedef fpcsr_t (4-bit), with index constants FLAG_NV=3, FLAG_OF=2, FLAG_UF=1, FLAG_NX=0
  - constant BF16_QNAN=16'h7FC0
  - FSM enum pack_state_e {EMPTY, HALF}
- One natural sub-module: bf16_out_reg, a single-entry valid/ready output register holding data, partial and flags.

Test Plan:
- Reset, then feed 16'h3F80 flags 0 and 16'h4000 flags 4'b0001, out_ready=1 → one cycle after the 2nd accept: out_data=32'h40003F80, out_partial=0, out_flags=4'b0001, word_count=1.
- Feed 16'h3F80, then flush alone → out_data=32'h00003F80, out_partial=1, FSM EMPTY.
- Hold out_ready=0 with one word pending and a half held, in_valid=1 → in_ready=0, out_data stable. Raise out_ready → next pair is accepted, no beat lost.
- Flags 4'b1000 then 4'b0100, then flags_clear together with an accept carrying 4'b0001 → sticky_flags goes 8 → C → 1.
- Stream 2^CNT_W words with CNT_W=4 → word_count wraps to 0.
- With BF16_PACK_NAN_CANON_EN, input 16'hFF81 → packed half = 16'h7FC0 and out_flags[3]=1. Without the macro → 16'hFF81 passes unchanged.
